pg_vf_flr_sched: RTL and testbench
==================================

// Module: pg_vf_flr_sched
// PURPOSE
//  Serialises per-port VF FLR events inside the port gasket into one-at-a-time requests for the port reset FSM.
//  Replaces the combinational priority pick, which drops FLRs that coincide on different ports.
//  Captures each FLR assertion and grants pending ports round-robin.
//  Holds the flr_rcvd_vf/vf_num sideband stable until the FSM reports done or a timeout fires.
// PARAMETERS
//  PG_NUM_PORTS   4     number of VF ports in the PR slot (1..32)
//  VFNUM_W        11    width of o_flr_rcvd_vf_num
//  TIMEOUT_CYCLES 4096  max WAIT_DONE cycles before forced release; 0 = timeout disabled
// PORTS
//  clk               in   1             clock, CSR domain
//  rst_n             in   1             asynchronous, active-low reset
//  i_func_vf_rst_n   in   PG_NUM_PORTS  per-port VF FLR reset, active-low level, synchronous to clk
//  i_flr_done        in   1             1-cycle pulse: reset FSM finished the current VF reset
//  i_err_clr         in   1             1-cycle pulse: clears o_timeout_err
//  o_flr_rcvd_vf     out  1             1-cycle request pulse to reset FSM
//  o_flr_rcvd_vf_num out  VFNUM_W       granted port + 1 (port0 = VF1); stable ISSUE..RELEASE
//  o_port_hold       out  PG_NUM_PORTS  one-hot: port currently being serviced
//  o_pending         out  PG_NUM_PORTS  captured, not-yet-issued FLRs
//  o_busy            out  1             state != IDLE
//  o_timeout_err     out  1             sticky: a WAIT_DONE timed out
// BEHAVIOUR
//  Reset values
//   - All outputs 0; state = IDLE; rr pointer = 0; timer = 0.
//   - prev_rst_n register = all ones.
//   - A port already low when reset releases is not captured.
//  Capture
//   - pending[i] is set on a sampled 1->0 transition of i_func_vf_rst_n[i] (prev_rst_n[i]=1, input=0).
//   - A held-low level does not re-trigger.
//  FSM (all outputs registered)
//   IDLE
//    - If |pending: grant = first set bit at or after rr_ptr, wrapping PG_NUM_PORTS-1 -> 0.
//    - Go to ISSUE.
//   ISSUE (1 cycle)
//    - o_flr_rcvd_vf = 1; o_flr_rcvd_vf_num = grant+1.
//    - o_port_hold[grant] = 1; clear pending[grant]; timer = 0.
//    - Go to WAIT_DONE.
//   WAIT_DONE
//    - o_flr_rcvd_vf = 0; num and hold are kept.
//    - On i_flr_done: go to RELEASE.
//    - Else if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1: o_timeout_err = 1, go to RELEASE.
//    - Else timer++.
//   RELEASE (1 cycle)
//    - o_port_hold = 0; o_flr_rcvd_vf_num = 0; rr_ptr = grant+1 (mod PG_NUM_PORTS).
//    - Go to IDLE.
//  Latency
//   - Input low first sampled at edge k: pending visible after k; ISSUE entered at k+1.
//   - o_flr_rcvd_vf is high in the cycle after edge k+2 when idle.
//   - Back-to-back service: RELEASE -> IDLE -> ISSUE = 2 idle cycles between requests.
//  Boundary conditions
//   - Set and clear of the same pending bit in one cycle: set wins, so a re-FLR of the granted port is re-queued.
//   - i_flr_done outside WAIT_DONE is ignored.
//   - i_flr_done on the timeout cycle: done wins, no error.
//   - i_err_clr and a new timeout in the same cycle: the error stays set.
//   - Timer width: $clog2(TIMEOUT_CYCLES+1); no wrap, because the cap forces RELEASE.
//   - rst_n asserted mid-operation: immediate return to reset values, with no pending pulse or hold left behind.
// TESTING
//  - Single FLR: port2 falls -> o_flr_rcvd_vf one pulse, num=3, hold=4'b0100.
//    - i_flr_done 10 cycles later -> hold=0 next cycle, busy=0 one cycle later.
//  - Simultaneous FLR: ports 0,1,3 fall together, rr_ptr=0 -> three pulses in order num=1,2,4.
//    - Each is issued only after the previous done; none is lost.
//  - Round-robin fairness: service port3 -> rr_ptr=0.
//    - Port3 re-FLR plus port0 FLR while busy -> port0 is served before port3.
//  - Timeout: TIMEOUT_CYCLES=16, no done -> RELEASE exactly 16 cycles after ISSUE.
//    - o_timeout_err=1 and sticky; i_err_clr pulse -> 0.
//  - Re-FLR of the granted port during WAIT_DONE -> pending set again, same port re-issued after RELEASE.
//    - Stray i_flr_done in IDLE -> no state change.
//  - Reset mid WAIT_DONE: rst_n low -> all outputs 0 asynchronously.
//    - After release, ports held low produce no pulse until they toggle high then low again.

Source files
------------

// File: rtl/pg_vf_flr_sched_if.sv
// Request/done handshake between the FLR scheduler and the port reset FSM.
// master = scheduler (drives request + VF number), slave = reset FSM.
interface pg_vf_flr_sched_if #(
  parameter int VFNUM_W = 11
);
  logic               o_flr_rcvd_vf;
  logic [VFNUM_W-1:0] o_flr_rcvd_vf_num;
  logic               i_flr_done;

  modport master (
    output o_flr_rcvd_vf,
    output o_flr_rcvd_vf_num,
    input  i_flr_done
  );

  modport slave (
    input  o_flr_rcvd_vf,
    input  o_flr_rcvd_vf_num,
    output i_flr_done
  );
endinterface

// File: rtl/pg_vf_flr_sched.sv
// Serialises per-port VF FLR falling edges into one-at-a-time, round-robin
// requests for the port reset FSM.
// Ports:
//   clk, rst_n       : clock and async active-low reset
//   i_func_vf_rst_n  : per-port VF FLR level, active low
//   i_err_clr        : pulse, clears o_timeout_err
//   o_port_hold      : one-hot port in service
//   o_pending        : captured FLRs not yet issued
//   o_busy           : FSM not idle (registered)
//   o_timeout_err    : sticky WAIT_DONE timeout flag
//   flr              : request pulse, VF number, done pulse
module pg_vf_flr_sched #(
  parameter int PG_NUM_PORTS   = 4,
  parameter int VFNUM_W        = 11,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PG_NUM_PORTS-1:0] i_func_vf_rst_n,
  input  logic                    i_err_clr,
  output logic [PG_NUM_PORTS-1:0] o_port_hold,
  output logic [PG_NUM_PORTS-1:0] o_pending,
  output logic                    o_busy,
  output logic                    o_timeout_err,
  pg_vf_flr_sched_if.master       flr
);

  localparam int N  = PG_NUM_PORTS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         prev_q;
  logic                 armed_q;
  logic [N-1:0]         pend_q, pend_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 req_q, req_d;
  logic [VFNUM_W-1:0]   num_q, num_d;
  logic [N-1:0]         hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [N-1:0]         fall;
  logic [N-1:0]         clr;
  logic [PW-1:0]        pick;
  logic                 found;

  // armed_q masks the first edge after reset, so a port that is
  // already low when reset releases is not seen as a new FLR.
  assign fall = prev_q & ~i_func_vf_rst_n & {N{armed_q}};

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!found && pend_q[(int'(rr_q) + o) % N]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_q) + o) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    req_d   = 1'b0;
    num_d   = num_q;
    hold_d  = hold_q;
    err_d   = err_q & ~i_err_clr;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        req_d   = 1'b1;
        num_d   = VFNUM_W'(grant_q) + VFNUM_W'(1);
        hold_d  = N'(1) << grant_q;
        clr     = N'(1) << grant_q;
        timer_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (flr.i_flr_done) begin
          state_d = RELEASE;
        end else if (TO_EN && timer_q == TLAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        hold_d  = '0;
        num_d   = '0;
        rr_d    = (grant_q == PW'(N - 1)) ?
                  '0 : grant_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh fall wins over the clear of the granted bit.
    pend_d = (pend_q & ~clr) | fall;
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '1;
      armed_q <= 1'b0;
      pend_q  <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      timer_q <= '0;
      req_q   <= 1'b0;
      num_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= i_func_vf_rst_n;
      armed_q <= 1'b1;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      num_q   <= num_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign flr.o_flr_rcvd_vf     = req_q;
  assign flr.o_flr_rcvd_vf_num = num_q;
  assign o_port_hold           = hold_q;
  assign o_pending             = pend_q;
  assign o_busy                = busy_q;
  assign o_timeout_err         = err_q;

endmodule

// File: tb/tb_pg_vf_flr_sched.sv
// Directed bench for pg_vf_flr_sched: capture, round-robin,
// timeout, boundary cases and async reset.
module tb_pg_vf_flr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vf;
  logic       err_clr;
  logic [3:0] hold;
  logic [3:0] pend;
  logic       busy;
  logic       err;
  int         n_chk = 0;
  int         n_fail = 0;

  pg_vf_flr_sched_if #(.VFNUM_W(11)) bus ();

  pg_vf_flr_sched #(
    .PG_NUM_PORTS  (4),
    .VFNUM_W       (11),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_func_vf_rst_n(vf),
    .i_err_clr      (err_clr),
    .o_port_hold    (hold),
    .o_pending      (pend),
    .o_busy         (busy),
    .o_timeout_err  (err),
    .flr            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done;
    bus.i_flr_done = 1'b1;
    tick;
    bus.i_flr_done = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick;
      if (bus.o_flr_rcvd_vf === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (busy === 1'b0 && pend === 4'b0 && hold === 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    vf = 4'hf;
    err_clr = 1'b0;
    bus.i_flr_done = 1'b0;
    repeat (3) tick;
    n_chk++;
    if ({bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_req: got %0h want 0",
               {bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num});
    end
    n_chk++;
    if ({hold, pend, busy, err} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %0h want 0",
               {hold, pend, busy, err});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_simultaneous;
    int n;
    int extra;
    bit ok;
    logic [10:0] exp_num [3] = '{11'd1, 11'd2, 11'd4};
    logic [3:0]  exp_pend[3] = '{4'b1010, 4'b1000, 4'b0000};
    vf = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      wait_req(n);
      n_chk++;
      if (n < 1) begin
        n_fail++;
        $display("FAIL simul_req%0d: got timeout want pulse", j);
      end
      n_chk++;
      if (bus.o_flr_rcvd_vf_num !== exp_num[j]) begin
        n_fail++;
        $display("FAIL simul_num%0d: got %0d want %0d",
                 j, bus.o_flr_rcvd_vf_num, exp_num[j]);
      end
      n_chk++;
      if (pend !== exp_pend[j]) begin
        n_fail++;
        $display("FAIL simul_pend%0d: got %b want %b",
                 j, pend, exp_pend[j]);
      end
      extra = 0;
      repeat (5) begin
        tick;
        if (bus.o_flr_rcvd_vf === 1'b1) extra++;
      end
      n_chk++;
      if (extra !== 0) begin
        n_fail++;
        $display("FAIL simul_early%0d: got %0d want 0", j, extra);
      end
      pulse_done;
    end
    wait_idle(ok);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_idle: got %b want 1", ok);
    end
    vf = 4'hf;
    tick;
  endtask

  task automatic test_single;
    vf = 4'b1011;
    tick;
    n_chk++;
    if ({pend, bus.o_flr_rcvd_vf} !== 5'b01000) begin
      n_fail++;
      $display("FAIL single_capture: got %b want 01000",
               {pend, bus.o_flr_rcvd_vf});
    end
    tick;
    n_chk++;
    if (bus.o_flr_rcvd_vf !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: got %b want 0",
               bus.o_flr_rcvd_vf);
    end
    tick;
    n_chk++;
    if ({bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num, hold, pend, busy}
        !== {1'b1, 11'd3, 4'b0100, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL single_issue: req=%b num=%0d hold=%b pend=%b busy=%b want 1 3 0100 0000 1",
               bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num,
               hold, pend, busy);
    end
    tick;
    n_chk++;
    if ({bus.o_flr_rcvd_vf, hold} !== {1'b0, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_wait: req=%b hold=%b want 0 0100",
               bus.o_flr_rcvd_vf, hold);
    end
    vf = 4'hf;
    repeat (8) tick;
    pulse_done;
    tick;
    n_chk++;
    if ({hold, bus.o_flr_rcvd_vf_num, busy}
        !== {4'b0, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_release: hold=%b num=%0d busy=%b want 0000 0 1",
               hold, bus.o_flr_rcvd_vf_num, busy);
    end
    tick;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_rr_fair;
    int n;
    bit ok;
    vf = 4'b0111;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd4) begin
      n_fail++;
      $display("FAIL rr_first: got %0d want 4", bus.o_flr_rcvd_vf_num);
    end
    vf = 4'hf;
    tick;
    vf = 4'b0110;
    tick;
    tick;
    n_chk++;
    if (pend !== 4'b1001) begin
      n_fail++;
      $display("FAIL rr_pend: got %b want 1001", pend);
    end
    pulse_done;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd1) begin
      n_fail++;
      $display("FAIL rr_port0: got %0d want 1", bus.o_flr_rcvd_vf_num);
    end
    pulse_done;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd4) begin
      n_fail++;
      $display("FAIL rr_port3: got %0d want 4", bus.o_flr_rcvd_vf_num);
    end
    pulse_done;
    vf = 4'hf;
    wait_idle(ok);
  endtask

  task automatic test_timeout;
    int n;
    int c;
    bit ok;
    vf = 4'b1101;
    wait_req(n);
    vf = 4'hf;
    c = -1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (err === 1'b1) begin
        c = i;
        break;
      end
    end
    n_chk++;
    if (c !== 16) begin
      n_fail++;
      $display("FAIL to_cycles: got %0d want 16", c);
    end
    n_chk++;
    if (hold !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_hold_kept: got %b want 0010", hold);
    end
    tick;
    n_chk++;
    if (hold !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_hold_rel: got %b want 0000", hold);
    end
    repeat (4) tick;
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky: got %b want 1", err);
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: got %b want 0", err);
    end
    wait_idle(ok);
  endtask

  task automatic test_done_at_timeout;
    int n;
    bit ok;
    vf = 4'b1101;
    wait_req(n);
    vf = 4'hf;
    repeat (15) tick;
    bus.i_flr_done = 1'b1;
    tick;
    bus.i_flr_done = 1'b0;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_vs_to: got %b want 0", err);
    end
    tick;
    n_chk++;
    if (hold !== 4'b0000) begin
      n_fail++;
      $display("FAIL done_vs_to_rel: got %b want 0000", hold);
    end
    wait_idle(ok);
  endtask

  task automatic test_clr_vs_timeout;
    int n;
    bit ok;
    vf = 4'b1110;
    wait_req(n);
    vf = 4'hf;
    repeat (15) tick;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_to: got %b want 1", err);
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_set_wins;
    int n;
    bit ok;
    vf = 4'b1110;
    tick;
    vf = 4'b1111;
    tick;
    vf = 4'b1110;
    tick;
    n_chk++;
    if ({bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num, pend}
        !== {1'b1, 11'd1, 4'b0001}) begin
      n_fail++;
      $display("FAIL set_wins: req=%b num=%0d pend=%b want 1 1 0001",
               bus.o_flr_rcvd_vf, bus.o_flr_rcvd_vf_num, pend);
    end
    pulse_done;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd1) begin
      n_fail++;
      $display("FAIL set_wins_reissue: got %0d want 1",
               bus.o_flr_rcvd_vf_num);
    end
    pulse_done;
    vf = 4'hf;
    wait_idle(ok);
  endtask

  task automatic test_reflr_wait;
    int n;
    bit ok;
    vf = 4'b1011;
    wait_req(n);
    vf = 4'hf;
    tick;
    vf = 4'b1011;
    tick;
    tick;
    n_chk++;
    if (pend !== 4'b0100) begin
      n_fail++;
      $display("FAIL reflr_pend: got %b want 0100", pend);
    end
    pulse_done;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd3) begin
      n_fail++;
      $display("FAIL reflr_reissue: got %0d want 3",
               bus.o_flr_rcvd_vf_num);
    end
    pulse_done;
    vf = 4'hf;
    wait_idle(ok);
    pulse_done;
    repeat (4) tick;
    n_chk++;
    if ({busy, bus.o_flr_rcvd_vf, hold, pend, bus.o_flr_rcvd_vf_num}
        !== 21'h0) begin
      n_fail++;
      $display("FAIL stray_done: got %0h want 0",
               {busy, bus.o_flr_rcvd_vf, hold, pend,
                bus.o_flr_rcvd_vf_num});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    bit ok;
    vf = 4'b1110;
    wait_req(n);
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({hold, busy, pend, bus.o_flr_rcvd_vf_num} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %0h want 0",
               {hold, busy, pend, bus.o_flr_rcvd_vf_num});
    end
    vf = 4'b1100;
    repeat (2) tick;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      tick;
      if (bus.o_flr_rcvd_vf === 1'b1 || pend !== 4'b0) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_held_low: got %0d want 0", seen);
    end
    vf = 4'b1111;
    tick;
    vf = 4'b1110;
    wait_req(n);
    n_chk++;
    if (bus.o_flr_rcvd_vf_num !== 11'd1) begin
      n_fail++;
      $display("FAIL rst_retoggle: got %0d want 1",
               bus.o_flr_rcvd_vf_num);
    end
    pulse_done;
    vf = 4'hf;
    wait_idle(ok);
  endtask

  initial begin
    test_reset;
    test_simultaneous;
    test_single;
    test_rr_fair;
    test_timeout;
    test_done_at_timeout;
    test_clr_vs_timeout;
    test_set_wins;
    test_reflr_wait;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
